// File: rtl/pac_pkg.sv
// Shared PAC constants: phi^n default ratios, oscillator pair map,
// ratio-engine state encoding and CHI thresholds used by the strength stage.
package pac_pkg;

    localparam int PAC_WIDTH     = 18;
    localparam int PAC_FRAC      = 14;
    localparam int PAC_NUM_PAIRS = 10;
    localparam int PAC_QBITS     = PAC_WIDTH + PAC_FRAC;
    localparam int PAC_NUM_SRC   = 8;
    localparam int PAC_PW        = 4;

    localparam logic [PAC_WIDTH-1:0] RATIO_PHI_1       = 18'd26510;
    localparam logic [PAC_WIDTH-1:0] RATIO_PHI_2       = 18'd42891;
    localparam logic [PAC_WIDTH-1:0] RATIO_PHI_BL_G    = 18'd33718;
    localparam logic [PAC_WIDTH-1:0] RATIO_PHI_BH_G    = 18'd20833;
    localparam logic [PAC_WIDTH-1:0] RATIO_PHI_TH_GF   = 18'd112249;
    localparam logic [PAC_WIDTH-1:0] RATIO_PHI_AL_GF   = 18'd69384;
    localparam logic [PAC_WIDTH-1:0] RATIO_TH_G_DEF    = 18'd88474;

    localparam logic [PAC_NUM_PAIRS*PAC_WIDTH-1:0] RATIO_RESET = {
        RATIO_TH_G_DEF, RATIO_PHI_2, RATIO_PHI_AL_GF, RATIO_PHI_TH_GF,
        RATIO_PHI_BH_G, RATIO_PHI_BL_G, RATIO_PHI_2, RATIO_PHI_1,
        RATIO_PHI_2, RATIO_PHI_1
    };

    localparam logic [PAC_WIDTH-1:0] CHI_LOW_THRESH  = 18'd4915;
    localparam logic [PAC_WIDTH-1:0] CHI_HIGH_THRESH = 18'd11469;

    localparam logic [2:0] SRC_THETA      = 3'd0;
    localparam logic [2:0] SRC_ALPHA      = 3'd1;
    localparam logic [2:0] SRC_BETA_LOW   = 3'd2;
    localparam logic [2:0] SRC_BETA_HIGH  = 3'd3;
    localparam logic [2:0] SRC_GAMMA      = 3'd4;
    localparam logic [2:0] SRC_GAMMA_FAST = 3'd5;
    localparam logic [2:0] SRC_SR_F0      = 3'd6;
    localparam logic [2:0] SRC_SR_F2      = 3'd7;

    localparam logic [PAC_PW-1:0] PAIR_TH_AL  = 4'd0;
    localparam logic [PAC_PW-1:0] PAIR_TH_BL  = 4'd1;
    localparam logic [PAC_PW-1:0] PAIR_AL_BL  = 4'd2;
    localparam logic [PAC_PW-1:0] PAIR_AL_BH  = 4'd3;
    localparam logic [PAC_PW-1:0] PAIR_BL_G   = 4'd4;
    localparam logic [PAC_PW-1:0] PAIR_BH_G   = 4'd5;
    localparam logic [PAC_PW-1:0] PAIR_TH_GF  = 4'd6;
    localparam logic [PAC_PW-1:0] PAIR_AL_GF  = 4'd7;
    localparam logic [PAC_PW-1:0] PAIR_F0_F2  = 4'd8;
    localparam logic [PAC_PW-1:0] PAIR_TH_G   = 4'd9;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DIV   = 3'd2;
    localparam logic [2:0] ST_STORE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic [2:0] lo;
        logic [2:0] hi;
    } pair_src_t;

    function automatic pair_src_t pair_src(input logic [PAC_PW-1:0] p);
        pair_src_t s;
        case (p)
            PAIR_TH_AL: s = '{SRC_THETA, SRC_ALPHA};
            PAIR_TH_BL: s = '{SRC_THETA, SRC_BETA_LOW};
            PAIR_AL_BL: s = '{SRC_ALPHA, SRC_BETA_LOW};
            PAIR_AL_BH: s = '{SRC_ALPHA, SRC_BETA_HIGH};
            PAIR_BL_G:  s = '{SRC_BETA_LOW, SRC_GAMMA};
            PAIR_BH_G:  s = '{SRC_BETA_HIGH, SRC_GAMMA};
            PAIR_TH_GF: s = '{SRC_THETA, SRC_GAMMA_FAST};
            PAIR_AL_GF: s = '{SRC_ALPHA, SRC_GAMMA_FAST};
            PAIR_F0_F2: s = '{SRC_SR_F0, SRC_SR_F2};
            PAIR_TH_G:  s = '{SRC_THETA, SRC_GAMMA};
            default:    s = '{SRC_THETA, SRC_GAMMA};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pac_seq_div.sv
// Restoring shift-subtract divider, one quotient bit per clk_en step.
// The dividend register shifts left and collects quotient bits in its LSB.
module pac_seq_div
    import pac_pkg::*;
#(
    parameter int WIDTH = PAC_WIDTH,
    parameter int QBITS = PAC_QBITS,
    parameter int CW    = $clog2(QBITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             load,
    input  logic             step,
    input  logic [QBITS-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_zero,
    output logic [QBITS-1:0] quotient,
    output logic             done_bit
);

    logic [QBITS-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH+1:0] rem_sh;
    logic             ge;

    assign div_zero = (divisor == '0);
    assign quotient = dvd_q;
    assign done_bit = (cnt_q == '0);
    assign rem_sh   = {rem_q, dvd_q[QBITS-1]};
    assign ge       = (rem_sh >= (WIDTH+2)'(dvs_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (clk_en) begin
            if (load) begin
                dvd_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
                cnt_q <= CW'(QBITS - 1);
            end else if (step) begin
                dvd_q <= {dvd_q[QBITS-2:0], ge};
                rem_q <= ge ? (WIDTH+1)'(rem_sh - (WIDTH+2)'(dvs_q))
                            : rem_sh[WIDTH:0];
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pac_ratio_calc.sv
// Time-multiplexed omega_high/omega_low ratio engine for the ten PAC pairs.
// Results are published together at the end of each sweep.
module pac_ratio_calc
    import pac_pkg::*;
#(
    parameter int WIDTH     = PAC_WIDTH,
    parameter int FRAC      = PAC_FRAC,
    parameter int NUM_PAIRS = PAC_NUM_PAIRS,
    parameter int QBITS     = WIDTH + FRAC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       start,
    input  logic [WIDTH-1:0]           omega_theta,
    input  logic [WIDTH-1:0]           omega_alpha,
    input  logic [WIDTH-1:0]           omega_beta_low,
    input  logic [WIDTH-1:0]           omega_beta_high,
    input  logic [WIDTH-1:0]           omega_gamma,
    input  logic [WIDTH-1:0]           omega_gamma_fast,
    input  logic [WIDTH-1:0]           omega_sr_f0,
    input  logic [WIDTH-1:0]           omega_sr_f2,
    output logic [NUM_PAIRS*WIDTH-1:0] ratio_flat,
    output logic [NUM_PAIRS-1:0]       div0_flags,
    output logic [NUM_PAIRS-1:0]       sat_flags,
    output logic                       busy,
    output logic                       done
);

    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [WIDTH-1:0]           omega_in [PAC_NUM_SRC];
    logic [WIDTH-1:0]           snap_q   [PAC_NUM_SRC];
    logic [2:0]                 state_q;
    logic [PAC_PW-1:0]          pair_q;
    logic                       zero_q;
    logic [NUM_PAIRS*WIDTH-1:0] work_ratio_q, ratio_nx;
    logic [NUM_PAIRS-1:0]       work_div0_q, div0_nx;
    logic [NUM_PAIRS-1:0]       work_sat_q, sat_nx;
    pair_src_t                  sel;
    logic [WIDTH-1:0]           om_lo, om_hi;
    logic                       div_zero, div_last, q_over;
    logic [QBITS-1:0]           quotient;
    logic [WIDTH-1:0]           store_val;

    assign omega_in[SRC_THETA]      = omega_theta;
    assign omega_in[SRC_ALPHA]      = omega_alpha;
    assign omega_in[SRC_BETA_LOW]   = omega_beta_low;
    assign omega_in[SRC_BETA_HIGH]  = omega_beta_high;
    assign omega_in[SRC_GAMMA]      = omega_gamma;
    assign omega_in[SRC_GAMMA_FAST] = omega_gamma_fast;
    assign omega_in[SRC_SR_F0]      = omega_sr_f0;
    assign omega_in[SRC_SR_F2]      = omega_sr_f2;

    assign sel   = pair_src(pair_q);
    assign om_lo = snap_q[sel.lo];
    assign om_hi = snap_q[sel.hi];
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);

    pac_seq_div #(.WIDTH(WIDTH), .QBITS(QBITS)) u_div (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .load     (state_q == ST_LOAD),
        .step     (state_q == ST_DIV),
        .dividend ({om_hi, {FRAC{1'b0}}}),
        .divisor  (om_lo),
        .div_zero (div_zero),
        .quotient (quotient),
        .done_bit (div_last)
    );

    // Any quotient bit above WIDTH means the ratio does not fit.
    assign q_over    = |quotient[QBITS-1:WIDTH];
    assign store_val = (zero_q || q_over) ? MAXV : quotient[WIDTH-1:0];

    always_comb begin
        ratio_nx = work_ratio_q;
        div0_nx  = work_div0_q;
        sat_nx   = work_sat_q;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (pair_q == i[PAC_PW-1:0]) begin
                ratio_nx[i*WIDTH +: WIDTH] = store_val;
                div0_nx[i] = zero_q;
                sat_nx[i]  = !zero_q && q_over;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pair_q       <= '0;
            zero_q       <= 1'b0;
            for (int i = 0; i < PAC_NUM_SRC; i++) snap_q[i] <= '0;
            work_ratio_q <= RATIO_RESET;
            work_div0_q  <= '0;
            work_sat_q   <= '0;
            ratio_flat   <= RATIO_RESET;
            div0_flags   <= '0;
            sat_flags    <= '0;
        end else if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < PAC_NUM_SRC; i++)
                            snap_q[i] <= omega_in[i];
                        work_div0_q <= '0;
                        work_sat_q  <= '0;
                        pair_q      <= '0;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    zero_q  <= div_zero;
                    state_q <= div_zero ? ST_STORE : ST_DIV;
                end
                ST_DIV: begin
                    if (div_last) state_q <= ST_STORE;
                end
                ST_STORE: begin
                    work_ratio_q <= ratio_nx;
                    work_div0_q  <= div0_nx;
                    work_sat_q   <= sat_nx;
                    if (pair_q == PAC_PW'(NUM_PAIRS - 1)) begin
                        ratio_flat <= ratio_nx;
                        div0_flags <= div0_nx;
                        sat_flags  <= sat_nx;
                        state_q    <= ST_DONE;
                    end else begin
                        pair_q  <= pair_q + 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pac_ratio_calc.sv
// Directed bench for pac_ratio_calc: defaults, normal, div0, saturation,
// clk_en throttling with mid-sweep disturbance, and reset abort.
module tb_pac_ratio_calc;

    localparam int W  = 18;
    localparam int NP = 10;

    logic          clk = 1'b0;
    logic          rst, clk_en, start;
    logic [W-1:0]  omega_theta, omega_alpha, omega_beta_low, omega_beta_high;
    logic [W-1:0]  omega_gamma, omega_gamma_fast, omega_sr_f0, omega_sr_f2;
    logic [NP*W-1:0] ratio_flat;
    logic [NP-1:0] div0_flags, sat_flags;
    logic          busy, done;

    int total = 0;
    int passed = 0;
    int exp_r[NP];
    int done_at, clk_n, en_n, busy_first, busy_cnt;

    pac_ratio_calc dut (
        .clk              (clk),
        .rst              (rst),
        .clk_en           (clk_en),
        .start            (start),
        .omega_theta      (omega_theta),
        .omega_alpha      (omega_alpha),
        .omega_beta_low   (omega_beta_low),
        .omega_beta_high  (omega_beta_high),
        .omega_gamma      (omega_gamma),
        .omega_gamma_fast (omega_gamma_fast),
        .omega_sr_f0      (omega_sr_f0),
        .omega_sr_f2      (omega_sr_f2),
        .ratio_flat       (ratio_flat),
        .div0_flags       (div0_flags),
        .sat_flags        (sat_flags),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
    endtask

    task automatic check_ratios(input string tag);
        for (int i = 0; i < NP; i++)
            chk($sformatf("%s_pair%0d", tag, i),
                {14'd0, ratio_flat[i*W +: W]}, 32'(exp_r[i]));
    endtask

    task automatic set_om(input int th, al, bl, bh, g, gf, f0, f2);
        omega_theta      = W'(th);
        omega_alpha      = W'(al);
        omega_beta_low   = W'(bl);
        omega_beta_high  = W'(bh);
        omega_gamma      = W'(g);
        omega_gamma_fast = W'(gf);
        omega_sr_f0      = W'(f0);
        omega_sr_f2      = W'(f2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep from IDLE and returns in the DONE cycle.
    task automatic run_sweep(input bit toggle, input bit mid);
        done_at = 0; clk_n = 0; en_n = 0;
        busy_first = 0; busy_cnt = 0;
        start = 1'b1;
        clk_en = 1'b1;
        while (clk_n < 2000) begin
            clk_n++;
            if (clk_en) begin
                en_n++;
                if (busy) begin
                    busy_cnt++;
                    if (busy_first == 0) busy_first = en_n;
                end
                if (done) begin
                    done_at = en_n;
                    break;
                end
            end
            tick();
            start = mid && (clk_n inside {[100:103]});
            if (mid && clk_n == 100) set_om(3, 9, 11, 13, 9999, 77, 5, 6);
            clk_en = toggle ? ~clk_en : 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; start = 1'b0;
        set_om(0, 0, 0, 0, 0, 0, 0, 0);
        exp_r = '{26510, 42891, 26510, 42891, 33718,
                  20833, 112249, 69384, 42891, 88474};
        repeat (2) tick();
        rst = 1'b0; clk_en = 1'b1;
        repeat (3) tick();
        check_ratios("reset");
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_div0", {22'd0, div0_flags}, 32'd0);
        chk("reset_sat", {22'd0, sat_flags}, 32'd0);

        set_om(152, 245, 397, 500, 817, 500, 500, 500);
        run_sweep(1'b0, 1'b0);
        chk("a_done_cycle", done_at, 32'd342);
        chk("a_busy_first", busy_first, 32'd2);
        chk("a_busy_cnt", busy_cnt, 32'd341);
        exp_r = '{26408, 42792, 26548, 33436, 33717,
                  26771, 53894, 33436, 16384, 88064};
        check_ratios("a");
        chk("a_div0", {22'd0, div0_flags}, 32'd0);
        chk("a_sat", {22'd0, sat_flags}, 32'd0);

        start = 1'b1;
        tick();
        chk("start_in_done", {31'd0, busy}, 32'd0);

        set_om(152, 0, 397, 500, 817, 500, 500, 500);
        run_sweep(1'b0, 1'b0);
        chk("b_done_cycle", done_at, 32'd246);
        exp_r = '{0, 42792, 262143, 262143, 33717,
                  26771, 53894, 262143, 16384, 88064};
        check_ratios("b");
        chk("b_div0", {22'd0, div0_flags}, 32'h08C);
        chk("b_sat", {22'd0, sat_flags}, 32'd0);
        tick();

        set_om(1, 8, 12, 100, 15, 1040, 500, 500);
        run_sweep(1'b0, 1'b0);
        chk("c_done_cycle", done_at, 32'd342);
        exp_r = '{131072, 196608, 24576, 204800, 20480,
                  2457, 262143, 262143, 16384, 245760};
        check_ratios("c");
        chk("c_div0", {22'd0, div0_flags}, 32'd0);
        chk("c_sat", {22'd0, sat_flags}, 32'h0C0);
        tick();

        set_om(152, 245, 397, 500, 817, 500, 500, 500);
        run_sweep(1'b1, 1'b1);
        chk("d_done_cycle", done_at, 32'd342);
        chk("d_clk_cycles", clk_n, 32'd683);
        exp_r = '{26408, 42792, 26548, 33436, 33717,
                  26771, 53894, 33436, 16384, 88064};
        check_ratios("d");
        chk("d_div0", {22'd0, div0_flags}, 32'd0);
        chk("d_sat", {22'd0, sat_flags}, 32'd0);
        tick();

        set_om(1, 8, 12, 100, 15, 1040, 500, 500);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (178) tick();
        chk("e_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        exp_r = '{26510, 42891, 26510, 42891, 33718,
                  20833, 112249, 69384, 42891, 88474};
        check_ratios("e_abort");
        chk("e_busy", {31'd0, busy}, 32'd0);
        chk("e_done", {31'd0, done}, 32'd0);
        chk("e_div0", {22'd0, div0_flags}, 32'd0);
        chk("e_sat", {22'd0, sat_flags}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        set_om(152, 245, 397, 500, 817, 500, 500, 500);
        run_sweep(1'b0, 1'b0);
        chk("f_done_cycle", done_at, 32'd342);
        exp_r = '{26408, 42792, 26548, 33436, 33717,
                  26771, 53894, 33436, 16384, 88064};
        check_ratios("f");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
